// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 key-search datapath.
//   prga_state_t      - state encoding of the keystream/decrypt FSM
//   MEM_SEL_*         - S-memory handler port-select codes per stage
//   CHAR_LO/HI/SP     - accepted plaintext alphabet (a..z and space)
//   DEFAULT_MSG_LEN   - default encrypted message length in bytes
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SI,
        ST_WT_SI,
        ST_GET_SI,
        ST_RD_SJ,
        ST_WT_SJ,
        ST_GET_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_WT_F,
        ST_GET_F,
        ST_WR_D,
        ST_NEXT,
        ST_DONE
    } prga_state_t;

    // Shuffle shares code 0 with "no owner"; the handler treats it as default.
    localparam logic [1:0] MEM_SEL_SHUFFLE = 2'd0;
    localparam logic [1:0] MEM_SEL_INIT    = 2'd1;
    localparam logic [1:0] MEM_SEL_DECRYPT = 2'd2;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    localparam int DEFAULT_MSG_LEN = 32;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// rc4_prga_decrypt_if: memory-side bundle of the PRGA/decrypt stage.
//   S-memory port (via handler): decrypt_mem_handler, memory_sel, address,
//                                data, wen, q_data
//   encrypted ROM:               address_m, q_m
//   decrypted RAM:               address_d, data_d, wren_d
// master = the decrypt stage, slave = memories / handler.
interface rc4_prga_decrypt_if;

    logic       decrypt_mem_handler;
    logic [1:0] memory_sel;
    logic [7:0] address;
    logic [7:0] data;
    logic       wen;
    logic [7:0] q_data;
    logic [7:0] address_m;
    logic [7:0] q_m;
    logic [7:0] address_d;
    logic [7:0] data_d;
    logic       wren_d;

    modport master (
        output decrypt_mem_handler, memory_sel, address, data, wen,
        output address_m, address_d, data_d, wren_d,
        input  q_data, q_m
    );

    modport slave (
        input  decrypt_mem_handler, memory_sel, address, data, wen,
        input  address_m, address_d, data_d, wren_d,
        output q_data, q_m
    );

endinterface

// File: rtl/rc4_char_check.sv
// rc4_char_check: combinational plaintext filter.
//   char_byte in  8  candidate plaintext byte
//   in_range  out 1  1 when the byte is 'a'..'z' or space
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] char_byte,
    output logic       in_range
);

    assign in_range = ((char_byte >= CHAR_LO) && (char_byte <= CHAR_HI)) ||
                      (char_byte == CHAR_SP);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 keystream generator and decryptor.
// Walks i/j over the already-shuffled S array, swaps S[i]/S[j], XORs
// S[S[i]+S[j]] with the encrypted ROM and writes the plaintext to RAM.
// Stops early on the first byte outside a..z/space.
//   clk, reset   system clock, synchronous active-high reset
//   state_start  level start from the shuffle stage
//   finish       high in DONE until state_start falls
//   key_valid    1 = all MSG_LEN bytes in range (valid while finish=1)
//   mem          S-memory, encrypted ROM and decrypted RAM ports
// All memory-side outputs are registered: an action listed for a state
// appears on the pins during the following cycle.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = DEFAULT_MSG_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               state_start,
    output logic               finish,
    output logic               key_valid,
    rc4_prga_decrypt_if.master mem
);

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    prga_state_t state;
    logic [7:0]  i, j, k, si, sj, f, enc;
    logic        handler;
    logic [1:0]  mem_sel;
    logic [7:0]  s_addr, s_wdata, d_addr, d_wdata;
    logic        s_wen, d_wen;
    logic [7:0]  plain;
    logic        plain_ok;

    assign plain = f ^ enc;

    rc4_char_check u_char_check (
        .char_byte (plain),
        .in_range  (plain_ok)
    );

    assign mem.decrypt_mem_handler = handler;
    assign mem.memory_sel          = mem_sel;
    assign mem.address             = s_addr;
    assign mem.data                = s_wdata;
    assign mem.wen                 = s_wen;
    assign mem.address_m           = k;
    assign mem.address_d           = d_addr;
    assign mem.data_d              = d_wdata;
    assign mem.wren_d              = d_wen;

    // NOTE: every register here is state, so only non-blocking assignments are
    // used; the write strobes get a default each cycle so they are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            f         <= '0;
            enc       <= '0;
            finish    <= 1'b0;
            key_valid <= 1'b0;
            handler   <= 1'b0;
            mem_sel   <= MEM_SEL_SHUFFLE;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wen     <= 1'b0;
            d_addr    <= '0;
            d_wdata   <= '0;
            d_wen     <= 1'b0;
        end else begin
            s_wen <= 1'b0;
            d_wen <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (state_start) begin
                        i         <= 8'd1;
                        j         <= 8'd0;
                        k         <= 8'd0;
                        key_valid <= 1'b0;
                        handler   <= 1'b1;
                        mem_sel   <= MEM_SEL_DECRYPT;
                        state     <= ST_RD_SI;
                    end
                end
                ST_RD_SI: begin
                    s_addr <= i;
                    state  <= ST_WT_SI;
                end
                ST_WT_SI:  state <= ST_GET_SI;
                ST_GET_SI: begin
                    si    <= mem.q_data;
                    j     <= j + mem.q_data;
                    state <= ST_RD_SJ;
                end
                ST_RD_SJ: begin
                    s_addr <= j;
                    state  <= ST_WT_SJ;
                end
                ST_WT_SJ:  state <= ST_GET_SJ;
                ST_GET_SJ: begin
                    sj    <= mem.q_data;
                    state <= ST_WR_SI;
                end
                ST_WR_SI: begin
                    s_addr  <= i;
                    s_wdata <= sj;
                    s_wen   <= 1'b1;
                    state   <= ST_WR_SJ;
                end
                // When i==j this second write lands on the same address and
                // leaves S[i] unchanged, which is the correct swap result.
                ST_WR_SJ: begin
                    s_addr  <= j;
                    s_wdata <= si;
                    s_wen   <= 1'b1;
                    state   <= ST_RD_F;
                end
                ST_RD_F: begin
                    s_addr <= si + sj;
                    state  <= ST_WT_F;
                end
                ST_WT_F:  state <= ST_GET_F;
                ST_GET_F: begin
                    f     <= mem.q_data;
                    enc   <= mem.q_m;
                    state <= ST_WR_D;
                end
                // The decrypted byte is written even when it aborts the run,
                // so the failing plaintext can be inspected afterwards.
                ST_WR_D: begin
                    d_addr  <= k;
                    d_wdata <= plain;
                    d_wen   <= 1'b1;
                    if (!plain_ok || (k == LAST_K)) begin
                        key_valid <= plain_ok;
                        handler   <= 1'b0;
                        mem_sel   <= MEM_SEL_SHUFFLE;
                        state     <= ST_DONE;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    k     <= k + 8'd1;
                    i     <= i + 8'd1;
                    state <= ST_RD_SI;
                end
                ST_DONE: begin
                    if (state_start) begin
                        finish <= 1'b1;
                    end else begin
                        finish  <= 1'b0;
                        k       <= '0;
                        s_addr  <= '0;
                        s_wdata <= '0;
                        d_addr  <= '0;
                        d_wdata <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb_rc4_prga_decrypt: directed bench for rc4_prga_decrypt.
// Instance a uses MSG_LEN=2 (hand-computed vectors), instance b uses
// MSG_LEN=32 against a behavioural RC4 model.
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    logic finish_a, kv_a, finish_b, kv_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rc4_prga_decrypt_if bus_a ();
    rc4_prga_decrypt_if bus_b ();

    rc4_prga_decrypt #(.MSG_LEN(2)) dut_a (
        .clk (clk), .reset (reset), .state_start (start_a),
        .finish (finish_a), .key_valid (kv_a), .mem (bus_a.master)
    );

    rc4_prga_decrypt #(.MSG_LEN(32)) dut_b (
        .clk (clk), .reset (reset), .state_start (start_b),
        .finish (finish_b), .key_valid (kv_b), .mem (bus_b.master)
    );

    // Memory models: 1-cycle registered-address reads, read-before-write.
    logic [7:0] s_a [256];
    logic [7:0] rom_a [256];
    logic [7:0] ram_a [256];
    logic [7:0] s_b [256];
    logic [7:0] rom_b [256];
    logic [7:0] ram_b [256];

    always @(posedge clk) begin
        bus_a.q_data <= s_a[bus_a.address];
        bus_a.q_m    <= rom_a[bus_a.address_m];
        if (bus_a.wen)    s_a[bus_a.address]     = bus_a.data;
        if (bus_a.wren_d) ram_a[bus_a.address_d] = bus_a.data_d;
        bus_b.q_data <= s_b[bus_b.address];
        bus_b.q_m    <= rom_b[bus_b.address_m];
        if (bus_b.wen)    s_b[bus_b.address]     = bus_b.data;
        if (bus_b.wren_d) ram_b[bus_b.address_d] = bus_b.data_d;
    end

    // Bus monitors.
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t wlog_a[$];
    int  overlap_a = 0, overlap_b = 0, wrd_cnt_a = 0, wen_cnt_b = 0;

    always @(negedge clk) begin
        if (bus_a.wen === 1'b1 && bus_a.wren_d === 1'b1) overlap_a++;
        if (bus_b.wen === 1'b1 && bus_b.wren_d === 1'b1) overlap_b++;
        if (bus_a.wen === 1'b1) wlog_a.push_back('{a: bus_a.address, d: bus_a.data});
        if (bus_a.wren_d === 1'b1) wrd_cnt_a++;
        if (bus_b.wen === 1'b1) wen_cnt_b++;
    end

    function automatic logic [46:0] outs_a();
        return {finish_a, kv_a, bus_a.decrypt_mem_handler, bus_a.memory_sel,
                bus_a.address, bus_a.data, bus_a.wen, bus_a.address_m,
                bus_a.address_d, bus_a.data_d, bus_a.wren_d};
    endfunction

    function automatic logic [46:0] outs_b();
        return {finish_b, kv_b, bus_b.decrypt_mem_handler, bus_b.memory_sel,
                bus_b.address, bus_b.data, bus_b.wen, bus_b.address_m,
                bus_b.address_d, bus_b.data_d, bus_b.wren_d};
    endfunction

    // Behavioural RC4 model state for instance b.
    logic [7:0] ms [256];
    logic [7:0] pt [32];

    task automatic prep_model_b(input bit shuffled);
        logic [7:0] key [3];
        logic [7:0] mi, mj, t, ks;
        int r;
        for (int x = 0; x < 256; x++) begin
            ms[x] = 8'(x); rom_b[x] = 8'h00; ram_b[x] = 8'hEE;
        end
        if (shuffled) begin
            for (int x = 0; x < 3; x++) key[x] = 8'($urandom);
            mj = 8'h00;
            for (int x = 0; x < 256; x++) begin
                mj = mj + ms[x] + key[x % 3];
                t = ms[x]; ms[x] = ms[mj]; ms[mj] = t;
            end
        end
        for (int x = 0; x < 256; x++) s_b[x] = ms[x];
        mi = 8'h00; mj = 8'h00;
        for (int n = 0; n < 32; n++) begin
            r = int'($urandom_range(0, 26));
            pt[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
            ks = ms[8'(ms[mi] + ms[mj])];
            rom_b[n] = pt[n] ^ ks;
        end
    endtask

    task automatic load_identity_a(input logic [7:0] e0, input logic [7:0] e1);
        for (int x = 0; x < 256; x++) begin
            s_a[x] = 8'(x); rom_a[x] = 8'h00; ram_a[x] = 8'hEE;
        end
        rom_a[0] = e0; rom_a[1] = e1;
        wlog_a.delete();
        wrd_cnt_a = 0; overlap_a = 0;
    endtask

    task automatic start_wait_a(output int edges);
        @(negedge clk);
        start_a = 1'b1;
        edges = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            edges++;
            if (finish_a === 1'b1) break;
        end
    endtask

    task automatic start_wait_b(output int edges);
        @(negedge clk);
        start_b = 1'b1;
        edges = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            edges++;
            if (finish_b === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (outs_a() !== '0) begin
            n_fail++; $display("FAIL reset_a: outputs %h expected 0", outs_a());
        end
        n_checks++;
        if (outs_b() !== '0) begin
            n_fail++; $display("FAIL reset_b: outputs %h expected 0", outs_b());
        end
        @(negedge clk); reset = 1'b0;
    endtask

    // Identity S, two bytes; also covers the i==j swap of byte 0.
    task automatic test_basic();
        int edges;
        wr_t exp_w [4];
        load_identity_a(8'h63, 8'h25);
        start_wait_a(edges);
        n_checks++;
        if (edges !== 27) begin
            n_fail++; $display("FAIL basic_latency: finish after %0d edges, expected 27", edges);
        end
        n_checks++;
        if (kv_a !== 1'b1) begin
            n_fail++; $display("FAIL basic_key_valid: got %b expected 1", kv_a);
        end
        n_checks++;
        if (ram_a[0] !== 8'h61 || ram_a[1] !== 8'h20) begin
            n_fail++; $display("FAIL basic_plain: d0=%h d1=%h expected 61 20", ram_a[0], ram_a[1]);
        end
        n_checks++;
        if (s_a[1] !== 8'h01 || s_a[2] !== 8'h03 || s_a[3] !== 8'h02) begin
            n_fail++; $display("FAIL basic_s: S1..3=%h %h %h expected 01 03 02", s_a[1], s_a[2], s_a[3]);
        end
        exp_w[0] = '{a: 8'h01, d: 8'h01};
        exp_w[1] = '{a: 8'h01, d: 8'h01};
        exp_w[2] = '{a: 8'h02, d: 8'h03};
        exp_w[3] = '{a: 8'h03, d: 8'h02};
        n_checks++;
        if (wlog_a.size() !== 4) begin
            n_fail++; $display("FAIL swap_wen_count: %0d S writes expected 4", wlog_a.size());
        end else begin
            for (int n = 0; n < 4; n++) begin
                n_checks++;
                if (wlog_a[n].a !== exp_w[n].a || wlog_a[n].d !== exp_w[n].d) begin
                    n_fail++;
                    $display("FAIL swap_write%0d: addr=%h data=%h expected addr=%h data=%h",
                             n, wlog_a[n].a, wlog_a[n].d, exp_w[n].a, exp_w[n].d);
                end
            end
        end
        n_checks++;
        if (wrd_cnt_a !== 2 || overlap_a !== 0) begin
            n_fail++; $display("FAIL basic_strobes: wren_d=%0d overlap=%0d expected 2 0", wrd_cnt_a, overlap_a);
        end
    endtask

    // Start held after DONE, then released.
    task automatic test_hold_release();
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            n_checks++;
            if (finish_a !== 1'b1 || bus_a.decrypt_mem_handler !== 1'b0 || bus_a.wen !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_done%0d: finish=%b handler=%b wen=%b expected 1 0 0",
                         n, finish_a, bus_a.decrypt_mem_handler, bus_a.wen);
            end
        end
        @(negedge clk); start_a = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (outs_a() !== {1'b0, 1'b1, 45'd0}) begin
            n_fail++; $display("FAIL release_idle: outputs %h expected key_valid only", outs_a());
        end
    endtask

    // First byte decrypts to 8'h02: abort after one byte.
    task automatic test_abort();
        int edges;
        load_identity_a(8'h00, 8'h25);
        start_wait_a(edges);
        n_checks++;
        if (edges !== 14) begin
            n_fail++; $display("FAIL abort_latency: finish after %0d edges, expected 14", edges);
        end
        n_checks++;
        if (kv_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_key_valid: got %b expected 0", kv_a);
        end
        n_checks++;
        if (ram_a[0] !== 8'h02 || ram_a[1] !== 8'hEE) begin
            n_fail++; $display("FAIL abort_ram: d0=%h d1=%h expected 02 EE", ram_a[0], ram_a[1]);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (wrd_cnt_a !== 1 || finish_a !== 1'b1) begin
            n_fail++; $display("FAIL abort_quiet: wren_d=%0d finish=%b expected 1 1", wrd_cnt_a, finish_a);
        end
        @(negedge clk); start_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_model_b(input string tag, input int edges);
        int bad_d, bad_s;
        bad_d = 0; bad_s = 0;
        n_checks++;
        if (edges !== 417) begin
            n_fail++; $display("FAIL %s_latency: finish after %0d edges, expected 417", tag, edges);
        end
        n_checks++;
        if (kv_b !== 1'b1) begin
            n_fail++; $display("FAIL %s_key_valid: got %b expected 1", tag, kv_b);
        end
        for (int n = 0; n < 32; n++) if (ram_b[n] !== pt[n]) bad_d++;
        for (int x = 0; x < 256; x++) if (s_b[x] !== ms[x]) bad_s++;
        n_checks++;
        if (bad_d !== 0) begin
            n_fail++; $display("FAIL %s_plain: %0d bytes differ, d0=%h expected %h", tag, bad_d, ram_b[0], pt[0]);
        end
        n_checks++;
        if (bad_s !== 0) begin
            n_fail++; $display("FAIL %s_final_s: %0d S entries differ from model", tag, bad_s);
        end
        n_checks++;
        if (wen_cnt_b !== 64 || overlap_b !== 0) begin
            n_fail++; $display("FAIL %s_wen: pulses=%0d overlap=%0d expected 64 0", tag, wen_cnt_b, overlap_b);
        end
        @(negedge clk); start_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_model(input bit shuffled);
        int edges;
        prep_model_b(shuffled);
        wen_cnt_b = 0; overlap_b = 0;
        start_wait_b(edges);
        check_model_b(shuffled ? "model_ksa" : "model_identity", edges);
    endtask

    // Reset while in WR_SI of byte 5, then a clean restart.
    task automatic test_reset_mid_run();
        int edges;
        prep_model_b(1'b1);
        wen_cnt_b = 0; overlap_b = 0;
        @(negedge clk); start_b = 1'b1;
        repeat (72) @(posedge clk);
        #1;
        n_checks++;
        if (wen_cnt_b !== 10 || bus_b.address_m !== 8'd5) begin
            n_fail++; $display("FAIL midrun_position: wen=%0d k=%0d expected 10 5", wen_cnt_b, bus_b.address_m);
        end
        reset = 1'b1; start_b = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (outs_b() !== '0) begin
            n_fail++; $display("FAIL midrun_reset: outputs %h expected 0", outs_b());
        end
        @(negedge clk); reset = 1'b0;
        prep_model_b(1'b1);
        wen_cnt_b = 0; overlap_b = 0;
        start_wait_b(edges);
        check_model_b("restart", edges);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_release();
        test_abort();
        test_model(1'b0);
        test_model(1'b1);
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
